// File: rtl/axis_header_rx_parser.sv
// axis_header_rx_parser
// AXI-Stream receiver for framed transfers: a six-word header (magic, four
// user fields, payload length) followed by the payload. Payload words are
// spread across BANK_COUNT BRAM banks, filling each bank before moving on to
// the next. One status pulse is raised per frame, in the cycle after the
// frame's terminating beat.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_HDR   | collecting header words 0..5
// S_DATA  | writing payload words to the BRAM banks
// S_DRAIN | discarding beats of a rejected frame until its tlast
//
// A bad magic word that also carries tlast ends the frame on that beat, so
// it reports err_code 1 at once instead of waiting in S_DRAIN for a tlast
// that belongs to the next frame.

module axis_header_rx_parser #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 9,
    parameter int                    BANK_COUNT   = 8,
    parameter logic [DATA_WIDTH-1:0] HEADER_MAGIC = 16'hA55A
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  rx_enable,
    input  logic [15:0]           cfg_words_per_bank,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [BANK_COUNT-1:0] bram_wr_en,
    output logic [DATA_WIDTH-1:0] hdr_field_1,
    output logic [DATA_WIDTH-1:0] hdr_field_2,
    output logic [DATA_WIDTH-1:0] hdr_field_3,
    output logic [DATA_WIDTH-1:0] hdr_field_4,
    output logic [DATA_WIDTH-1:0] hdr_length,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [1:0]            err_code
);

    localparam int BANK_W = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
    localparam int LEN_W  = DATA_WIDTH + 1;
    localparam int WPB_W  = 16;

    localparam logic [2:0] HDR_LAST  = 3'd5;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MAGIC = 2'd1;
    localparam logic [1:0] ERR_EARLY = 2'd2;
    localparam logic [1:0] ERR_LEN   = 2'd3;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_DATA  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [2:0]            r_hdr_idx;
    logic [DATA_WIDTH-1:0] r_sh1, r_sh2, r_sh3, r_sh4;
    logic [DATA_WIDTH-1:0] r_len;
    logic [WPB_W-1:0]      r_wpb;
    logic [BANK_W-1:0]     r_bank;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_remaining;
    logic [1:0]            r_drain_code;

    logic                  w_accept;
    logic                  w_done;
    logic                  w_err;
    logic [1:0]            w_err_code;
    logic [1:0]            w_drain_code;
    logic [LEN_W-1:0]      w_capacity;
    logic                  w_overflow;
    logic                  w_addr_last;

    assign w_accept    = s_axis_tvalid && rx_enable;
    assign w_capacity  = LEN_W'(BANK_COUNT) * LEN_W'(cfg_words_per_bank);
    assign w_overflow  = LEN_W'(s_axis_tdata) > w_capacity;
    assign w_addr_last = (WPB_W'(r_addr) == (r_wpb - WPB_W'(1)));

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and end-of-frame events, decided on each accepted beat
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_err_code   = ERR_NONE;
        w_drain_code = r_drain_code;
        case (r_state)
            S_HDR: begin
                if (w_accept) begin
                    if (r_hdr_idx == 3'd0) begin
                        if (s_axis_tdata != HEADER_MAGIC) begin
                            if (s_axis_tlast) begin
                                w_err      = 1'b1;
                                w_err_code = ERR_MAGIC;
                            end else begin
                                w_drain_code = ERR_MAGIC;
                                w_next_state = S_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            w_err      = 1'b1;
                            w_err_code = ERR_EARLY;
                        end
                    end else if (r_hdr_idx != HDR_LAST) begin
                        if (s_axis_tlast) begin
                            w_err      = 1'b1;
                            w_err_code = ERR_EARLY;
                        end
                    end else if (s_axis_tdata == '0) begin
                        if (s_axis_tlast) begin
                            w_done = 1'b1;
                        end else begin
                            w_drain_code = ERR_LEN;
                            w_next_state = S_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_EARLY;
                    end else if (w_overflow) begin
                        w_drain_code = ERR_LEN;
                        w_next_state = S_DRAIN;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (r_remaining == DATA_WIDTH'(1)) begin
                        if (s_axis_tlast) begin
                            w_done       = 1'b1;
                            w_next_state = S_HDR;
                        end else begin
                            w_drain_code = ERR_LEN;
                            w_next_state = S_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        w_err        = 1'b1;
                        w_err_code   = ERR_EARLY;
                        w_next_state = S_HDR;
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept && s_axis_tlast) begin
                    w_err        = 1'b1;
                    w_err_code   = r_drain_code;
                    w_next_state = S_HDR;
                end
            end
            default: begin
                w_next_state = S_HDR;
            end
        endcase
    end

    // Stream handshake: readiness follows rx_enable in every state
    always_comb begin
        s_axis_tready = rx_enable;
    end

    // Header capture, bank/address walk and payload countdown
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hdr_idx    <= '0;
            r_sh1        <= '0;
            r_sh2        <= '0;
            r_sh3        <= '0;
            r_sh4        <= '0;
            r_len        <= '0;
            r_wpb        <= '0;
            r_bank       <= '0;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_drain_code <= ERR_NONE;
        end else if (w_accept) begin
            r_drain_code <= w_drain_code;
            case (r_state)
                S_HDR: begin
                    if (w_next_state != S_HDR || w_done || w_err) begin
                        r_hdr_idx <= '0;
                    end else begin
                        r_hdr_idx <= r_hdr_idx + 3'd1;
                    end
                    case (r_hdr_idx)
                        3'd1: r_sh1 <= s_axis_tdata;
                        3'd2: r_sh2 <= s_axis_tdata;
                        3'd3: r_sh3 <= s_axis_tdata;
                        3'd4: r_sh4 <= s_axis_tdata;
                        3'd5: begin
                            r_len       <= s_axis_tdata;
                            r_wpb       <= cfg_words_per_bank;
                            r_bank      <= '0;
                            r_addr      <= '0;
                            r_remaining <= s_axis_tdata;
                        end
                        default: ;
                    endcase
                end
                S_DATA: begin
                    if (w_addr_last) begin
                        r_addr <= '0;
                        r_bank <= r_bank + BANK_W'(1);
                    end else begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                    r_remaining <= r_remaining - DATA_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered BRAM write port and per-frame status outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bram_wr_en   <= '0;
            bram_wr_data <= '0;
            bram_wr_addr <= '0;
            hdr_field_1  <= '0;
            hdr_field_2  <= '0;
            hdr_field_3  <= '0;
            hdr_field_4  <= '0;
            hdr_length   <= '0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            bram_wr_en  <= '0;
            frame_done  <= w_done;
            frame_error <= w_err;
            if (w_accept && r_state == S_DATA) begin
                bram_wr_en   <= BANK_COUNT'(1) << r_bank;
                bram_wr_data <= s_axis_tdata;
                bram_wr_addr <= r_addr;
            end
            if (w_done) begin
                err_code    <= ERR_NONE;
                hdr_field_1 <= r_sh1;
                hdr_field_2 <= r_sh2;
                hdr_field_3 <= r_sh3;
                hdr_field_4 <= r_sh4;
                // a zero-length frame finishes on the length word itself
                hdr_length  <= (r_state == S_HDR) ? s_axis_tdata : r_len;
            end else if (w_err) begin
                err_code <= w_err_code;
            end
        end
    end

endmodule

// File: tb/tb_axis_header_rx_parser.sv
// Scoreboard bench for axis_header_rx_parser: a frame-level reference model
// pushes expected BRAM writes and status pulses; a negedge monitor pops them.

module tb_axis_header_rx_parser;

    localparam logic [15:0] MAGIC = 16'hA55A;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        rx_enable = 1'b0;
    logic [15:0] cfg_words_per_bank = 16'd512;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [15:0] bram_wr_data;
    logic [8:0]  bram_wr_addr;
    logic [7:0]  bram_wr_en;
    logic [15:0] hdr_field_1, hdr_field_2, hdr_field_3, hdr_field_4, hdr_length;
    logic        frame_done, frame_error;
    logic [1:0]  err_code;

    axis_header_rx_parser dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .rx_enable          (rx_enable),
        .cfg_words_per_bank (cfg_words_per_bank),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .bram_wr_data       (bram_wr_data),
        .bram_wr_addr       (bram_wr_addr),
        .bram_wr_en         (bram_wr_en),
        .hdr_field_1        (hdr_field_1),
        .hdr_field_2        (hdr_field_2),
        .hdr_field_3        (hdr_field_3),
        .hdr_field_4        (hdr_field_4),
        .hdr_length         (hdr_length),
        .frame_done         (frame_done),
        .frame_error        (frame_error),
        .err_code           (err_code)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [7:0]  en;
        logic [8:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [15:0] h1, h2, h3, h4, hl;
    } st_t;

    wr_t         wq[$];
    st_t         sq[$];
    logic [16:0] fr[$];
    logic [15:0] mdl_hdr[5];
    logic [15:0] mon_hdr[5];
    logic [1:0]  mon_code;
    wr_t         mw;
    st_t         ms;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          gaps = 0;
    bit          last_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    task automatic push_status(input bit err, input logic [1:0] code);
        st_t s;
        s.err  = err;
        s.code = code;
        s.h1   = mdl_hdr[0];
        s.h2   = mdl_hdr[1];
        s.h3   = mdl_hdr[2];
        s.h4   = mdl_hdr[3];
        s.hl   = mdl_hdr[4];
        sq.push_back(s);
    endtask

    task automatic push_write(input int i, input int wpb, input logic [15:0] d);
        wr_t w;
        w.en   = 8'(1 << (i / wpb));
        w.addr = 9'(i % wpb);
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic mark_done();
        for (int k = 0; k < 5; k++) mdl_hdr[k] = fr[k+1][15:0];
        push_status(1'b0, 2'd0);
    endtask

    // Frames always carry tlast on their final beat only.
    task automatic model_frame(input int wpb);
        int n, len, p;
        n = fr.size();
        if (fr[0][15:0] != MAGIC) push_status(1'b1, 2'd1);
        else if (n < 6) push_status(1'b1, 2'd2);
        else begin
            len = int'(fr[5][15:0]);
            if (len == 0) begin
                if (n == 6) mark_done();
                else push_status(1'b1, 2'd3);
            end else if (n == 6) push_status(1'b1, 2'd2);
            else if (len > 8 * wpb) push_status(1'b1, 2'd3);
            else begin
                p = n - 6;
                for (int i = 0; i < p && i < len; i++) push_write(i, wpb, fr[6+i][15:0]);
                if (p < len) push_status(1'b1, 2'd2);
                else if (p == len) mark_done();
                else push_status(1'b1, 2'd3);
            end
        end
    endtask

    // seq=1: header fields 1..4 and payload 0,1,2,...; otherwise random
    task automatic build(input logic [15:0] w0, input logic [15:0] len, input int nbeats, input bit seq);
        fr.delete();
        fr.push_back({1'b0, w0});
        for (int k = 1; k < 6 && k < nbeats; k++)
            fr.push_back({1'b0, (k == 5) ? len : (seq ? 16'(k) : 16'($urandom))});
        for (int i = 6; i < nbeats; i++)
            fr.push_back({1'b0, seq ? 16'(i - 6) : 16'($urandom)});
        fr[fr.size()-1][16] = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [15:0] d, input logic l);
        int budget;
        bit acc;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                s_axis_tvalid = 1'b0;
                rx_enable = ($urandom_range(0, 1) == 1);
                @(posedge aclk);
                #1;
            end
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        budget = 0;
        acc = 1'b0;
        while (!acc) begin
            rx_enable = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge aclk);
            acc = rx_enable && s_axis_tready;
            #1;
            budget++;
            if (!acc && budget > 64) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout actual=%0d required=accept", budget);
                acc = 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_frame(input int wpb);
        cfg_words_per_bank = 16'(wpb);
        model_frame(wpb);
        for (int i = 0; i < fr.size(); i++) drive_beat(fr[i][15:0], fr[i][16]);
    endtask

    // ---------------- monitor ----------------
    always @(posedge aclk) last_acc = s_axis_tvalid && rx_enable;

    always @(negedge aclk) begin
        if (aresetn) begin
            check("tready", 64'(s_axis_tready), 64'(rx_enable));
            if (bram_wr_en != 8'd0) begin
                check("wr_latency", 64'(last_acc), 64'd1);
                if (wq.size() == 0) check("wr_unexpected", 64'(bram_wr_en), 64'd0);
                else begin
                    mw = wq.pop_front();
                    check("wr_en", 64'(bram_wr_en), 64'(mw.en));
                    check("wr_addr", 64'(bram_wr_addr), 64'(mw.addr));
                    check("wr_data", 64'(bram_wr_data), 64'(mw.data));
                end
            end
            if (frame_done || frame_error) begin
                check("pulse_latency", 64'(last_acc), 64'd1);
                if (sq.size() == 0) check("status_unexpected", 64'({frame_done, frame_error}), 64'd0);
                else begin
                    ms = sq.pop_front();
                    check("frame_done", 64'(frame_done), 64'(!ms.err));
                    check("frame_error", 64'(frame_error), 64'(ms.err));
                    mon_code   = ms.code;
                    mon_hdr[0] = ms.h1;
                    mon_hdr[1] = ms.h2;
                    mon_hdr[2] = ms.h3;
                    mon_hdr[3] = ms.h4;
                    mon_hdr[4] = ms.hl;
                end
            end
            check("err_code", 64'(err_code), 64'(mon_code));
            check("hdr_field_1", 64'(hdr_field_1), 64'(mon_hdr[0]));
            check("hdr_field_2", 64'(hdr_field_2), 64'(mon_hdr[1]));
            check("hdr_field_3", 64'(hdr_field_3), 64'(mon_hdr[2]));
            check("hdr_field_4", 64'(hdr_field_4), 64'(mon_hdr[3]));
            check("hdr_length", 64'(hdr_length), 64'(mon_hdr[4]));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 64'(bram_wr_en), 64'd0);
        check({tag, "_wr_data"}, 64'(bram_wr_data), 64'd0);
        check({tag, "_wr_addr"}, 64'(bram_wr_addr), 64'd0);
        check({tag, "_hdr"}, 64'({hdr_field_1, hdr_field_2, hdr_field_3, hdr_field_4}), 64'd0);
        check({tag, "_hdr_length"}, 64'(hdr_length), 64'd0);
        check({tag, "_status"}, 64'({frame_done, frame_error, err_code}), 64'd0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 5; k++) begin
            mdl_hdr[k] = '0;
            mon_hdr[k] = '0;
        end
        mon_code = 2'd0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wpb, len, npay, kind;
        logic [15:0] w0;
        clear_model();
        #2 aresetn = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: 1024 words over two 512-word banks
        build(MAGIC, 16'd1024, 1030, 1'b1);
        run_frame(512);
        // 2: notification-only frame
        build(MAGIC, 16'd0, 6, 1'b0);
        run_frame(512);
        // 3: bad magic drained, then a good frame
        build(16'd1234, 16'd0, 4, 1'b0);
        run_frame(4);
        build(MAGIC, 16'd3, 9, 1'b0);
        run_frame(2);
        // 4: early tlast in payload, overflow, missing tlast, header errors
        build(MAGIC, 16'd8, 11, 1'b0);
        run_frame(4);
        build(MAGIC, 16'd4096, 8, 1'b0);
        run_frame(256);
        build(MAGIC, 16'd4, 12, 1'b0);
        run_frame(4);
        build(MAGIC, 16'd0, 4, 1'b0);
        run_frame(4);
        build(MAGIC, 16'd0, 8, 1'b0);
        run_frame(4);
        build(MAGIC, 16'd5, 6, 1'b0);
        run_frame(4);
        build(MAGIC, 16'd0, 1, 1'b0);
        run_frame(4);
        // capacity boundaries
        build(MAGIC, 16'd8, 14, 1'b0);
        run_frame(1);
        build(MAGIC, 16'd24, 30, 1'b0);
        run_frame(3);
        build(MAGIC, 16'd25, 31, 1'b0);
        run_frame(3);
        // 5: frame 1 again under random gaps and rx_enable stalls
        gaps = 1'b1;
        build(MAGIC, 16'd1024, 1030, 1'b1);
        run_frame(512);
        gaps = 1'b0;
        rx_enable = 1'b1;

        // reset mid-payload: six writes expected, the seventh is cut by reset
        cfg_words_per_bank = 16'd4;
        build(MAGIC, 16'd16, 22, 1'b0);
        for (int i = 0; i < 6; i++) push_write(i, 4, fr[6+i][15:0]);
        for (int i = 0; i < 13; i++) drive_beat(fr[i][15:0], fr[i][16]);
        check("pre_reset_wr_en", 64'(bram_wr_en), 64'h2);
        check("pre_reset_wr_addr", 64'(bram_wr_addr), 64'd2);
        #1 aresetn = 1'b0;
        #1 check_all_zero("mid_reset");
        check("reset_wq_empty", 64'(wq.size()), 64'd0);
        check("reset_sq_empty", 64'(sq.size()), 64'd0);
        clear_model();
        @(posedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        build(MAGIC, 16'd7, 13, 1'b0);
        run_frame(2);

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            gaps = ($urandom_range(0, 1) == 1);
            wpb  = $urandom_range(1, 12);
            kind = $urandom_range(0, 9);
            w0   = MAGIC;
            case (kind)
                6: begin len = $urandom_range(2, 8 * wpb); npay = $urandom_range(1, len - 1); end
                7: begin len = $urandom_range(1, 8 * wpb); npay = len + $urandom_range(1, 2); end
                8: begin
                    len = 0; npay = 0;
                    if ($urandom_range(0, 1) == 1) w0 = 16'h1000 + 16'($urandom_range(0, 255));
                end
                9: begin len = 8 * wpb + $urandom_range(1, 5); npay = $urandom_range(1, 3); end
                default: begin len = $urandom_range(1, 8 * wpb); npay = len; end
            endcase
            build(w0, 16'(len), 6 + npay, 1'b0);
            run_frame(wpb);
        end
        gaps = 1'b0;
        rx_enable = 1'b1;

        for (int t = 0; t < 20 && (wq.size() != 0 || sq.size() != 0); t++) @(posedge aclk);
        #1;
        check("final_wq_empty", 64'(wq.size()), 64'd0);
        check("final_sq_empty", 64'(sq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
